// File: rtl/hash_feature_fetch_pkg.sv
// Shared widths and tag/response records for the hash-address feature fetch path.
package hash_feature_fetch_pkg;
  localparam int HASH_ADDR_W = 11;
  localparam int FEAT_W      = 32;
  localparam int LEVEL_W     = 3;

  typedef struct packed {
    logic [LEVEL_W-1:0] level;
    logic               last;
  } fetch_tag_t;

  typedef struct packed {
    logic [FEAT_W-1:0] feat;
    fetch_tag_t        tag;
  } fetch_resp_t;
endpackage

// File: rtl/hash_feature_fetch_if.sv
// Request, SRAM read and feature-return signals of the fetch stage.
// slave = the fetch block's view, master = the encoder/SRAM/consumer side.
interface hash_feature_fetch_if;
  import hash_feature_fetch_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [63:0]            in_hash_addr;
  logic [LEVEL_W-1:0]     in_level;
  logic                   in_last;
  logic                   mem_rd_en;
  logic [HASH_ADDR_W-1:0] mem_rd_addr;
  logic [FEAT_W-1:0]      mem_rd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [FEAT_W-1:0]      out_feat;
  logic [LEVEL_W-1:0]     out_level;
  logic                   out_last;
  logic                   err_oob;
  logic [31:0]            req_count;

  modport slave (
    input  in_valid, in_hash_addr, in_level, in_last, mem_rd_data, out_ready,
    output in_ready, mem_rd_en, mem_rd_addr, out_valid, out_feat, out_level, out_last,
    output err_oob, req_count
  );

  modport master (
    output in_valid, in_hash_addr, in_level, in_last, mem_rd_data, out_ready,
    input  in_ready, mem_rd_en, mem_rd_addr, out_valid, out_feat, out_level, out_last,
    input  err_oob, req_count
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, show-ahead read; push on full is accepted only alongside a pop.
// Latency 1 cycle push->visible; no internal backpressure beyond count/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/hash_feature_fetch.sv
// Issues feature-table reads for hash addresses and returns words in order; in->out MEM_LAT+1 cycles.
// Credits cover FIFO entries plus in-flight reads, so out_ready stalls never drop SRAM data.
module hash_feature_fetch
  import hash_feature_fetch_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  hash_feature_fetch_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic               accept, oob, push, pop, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [MEM_LAT-1:0] vld_sr;
  fetch_tag_t         tag_sr [MEM_LAT];
  fetch_resp_t        push_dat, head;
  int unsigned        inflight;
  logic               err_q;
  logic [31:0]        cnt_q;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + 32'(vld_sr[i]);
  end

  // Free credits = depth minus everything already owed a FIFO slot.
  assign bus.in_ready = !rst && ((32'(fifo_count) + inflight) < $unsigned(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign oob          = |bus.in_hash_addr[63:HASH_ADDR_W];

  assign bus.mem_rd_en   = accept;
  assign bus.mem_rd_addr = bus.in_hash_addr[HASH_ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int i = 1; i < MEM_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_sr[0] <= '{level: bus.in_level, last: bus.in_last};
    for (int i = 1; i < MEM_LAT; i++) tag_sr[i] <= tag_sr[i-1];
  end

  assign push     = vld_sr[MEM_LAT-1];
  assign push_dat = '{feat: bus.mem_rd_data, tag: tag_sr[MEM_LAT-1]};
  assign pop      = bus.out_valid && bus.out_ready;

  sync_fifo #(
    .WIDTH ($bits(fetch_resp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // Masked by rst so a stale head is never offered during the reset cycle.
  assign bus.out_valid = !fifo_empty && !rst;
  assign bus.out_feat  = head.feat;
  assign bus.out_level = head.tag.level;
  assign bus.out_last  = head.tag.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 32'd1;
      if (oob) err_q <= 1'b1;
    end
  end

  assign bus.err_oob   = err_q;
  assign bus.req_count = cnt_q;
endmodule

// File: tb/tb_hash_feature_fetch.sv
// Directed and random stimulus for hash_feature_fetch against an in-order request/response model.
`timescale 1ns/1ps
module tb_hash_feature_fetch;
  import hash_feature_fetch_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_feature_fetch_if bus();

  hash_feature_fetch #(.MEM_LAT(MEM_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Feature-table SRAM with two-cycle read latency.
  logic [31:0] sram [2048];
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    if (bus.mem_rd_en) p1 <= sram[bus.mem_rd_addr];
    p2 <= p1;
  end
  assign bus.mem_rd_data = p2;

  typedef struct {
    logic [31:0] feat;
    logic [2:0]  level;
    logic        last;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_feat[$];
  logic        obs_last[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        m_err;
  logic [31:0] m_cnt;
  logic        m_vld, m_acc;
  exp_t        m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: actual %h required %h", name, cyc, act, req);
    end
  endtask

  // Per-cycle comparison: a request accepted in cycle c is owed at the head from cycle c+MEM_LAT+1.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
      exp_q.delete();
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      m_vld = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
      if (m_vld) begin
        chk("out_feat", 64'(bus.out_feat), 64'(exp_q[0].feat));
        chk("out_level", 64'(bus.out_level), 64'(exp_q[0].level));
        chk("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
      end
      m_acc = bus.in_valid && bus.in_ready;
      chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(m_acc));
      if (m_acc) chk("mem_rd_addr", 64'(bus.mem_rd_addr), 64'(bus.in_hash_addr[10:0]));
      chk("err_oob", 64'(bus.err_oob), 64'(m_err));
      chk("req_count", 64'(bus.req_count), 64'(m_cnt));
      if (m_vld && bus.out_ready) begin
        obs_feat.push_back(bus.out_feat);
        obs_last.push_back(bus.out_last);
        void'(exp_q.pop_front());
      end
      if (m_acc) begin
        m_e.feat  = sram[bus.in_hash_addr[10:0]];
        m_e.level = bus.in_level;
        m_e.last  = bus.in_last;
        m_e.due   = cyc + MEM_LAT + 1;
        exp_q.push_back(m_e);
        m_cnt = m_cnt + 32'd1;
        if (bus.in_hash_addr[63:11] != '0) m_err = 1'b1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] h, input logic [2:0] lv, input logic ls);
    bus.in_valid     = 1'b1;
    bus.in_hash_addr = h;
    bus.in_level     = lv;
    bus.in_last      = ls;
  endtask

  int   lat, acc, nxt, n_acc, n_cyc, seen;
  logic found, took, hold;

  initial begin
    for (int i = 0; i < 2048; i++) sram[i] = (i < 16) ? (32'hA5A5_0000 | 32'(i)) : $urandom;
    bus.in_valid = 1'b0; bus.in_hash_addr = '0; bus.in_level = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_count", 64'(bus.req_count), 64'd0);
    chk("reset_err_oob", 64'(bus.err_oob), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // 1: single request, latency and data
    drive(64'h5, 3'd2, 1'b0);
    @(negedge clk);
    chk("t1_rd_en", 64'(bus.mem_rd_en), 64'd1);
    chk("t1_rd_addr", 64'(bus.mem_rd_addr), 64'h5);
    step();
    bus.in_valid = 1'b0;
    found = 1'b0; lat = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = 1'b1; lat = k;
        chk("t1_feat", 64'(bus.out_feat), 64'hA5A5_0005);
        chk("t1_level", 64'(bus.out_level), 64'd2);
        chk("t1_last", 64'(bus.out_last), 64'd0);
      end
    end
    chk("t1_latency", 64'(lat), 64'd3);
    step();

    // 2: five levels back to back
    obs_feat.delete(); obs_last.delete();
    for (int i = 1; i <= 5; i++) begin
      drive(64'(i), 3'(i - 1), i == 5);
      @(negedge clk);
      chk("t2_in_ready", 64'(bus.in_ready), 64'd1);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (8) step();
    chk("t2_count", 64'(obs_feat.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_feat.size(); i++) begin
      chk("t2_feat", 64'(obs_feat[i]), 64'(32'hA5A5_0001 + 32'(i)));
      chk("t2_last", 64'(obs_last[i]), 64'(i == 4));
    end

    // 3: stalled output fills exactly DEPTH credits
    bus.out_ready = 1'b0;
    nxt = 6; acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(64'(nxt), 3'd0, 1'b0);
      @(negedge clk);
      took = bus.in_ready;
      if (took) acc++;
      step();
      if (took) nxt++;
    end
    chk("t3_accepts", 64'(acc), 64'd4);
    @(negedge clk);
    chk("t3_in_ready_full", 64'(bus.in_ready), 64'd0);
    step();
    obs_feat.delete(); obs_last.delete();
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = bus.in_ready;
      step();
    end
    chk("t3_resumed", 64'(found), 64'd1);
    bus.in_valid = 1'b0;
    repeat (8) step();
    chk("t3_count", 64'(obs_feat.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_feat.size(); i++)
      chk("t3_feat", 64'(obs_feat[i]), 64'(32'hA5A5_0006 + 32'(i)));

    // 4: out-of-range hash bits
    @(negedge clk);
    chk("t4_err_before", 64'(bus.err_oob), 64'd0);
    step();
    drive(64'h0000_0000_0000_0848, 3'd1, 1'b0);
    @(negedge clk);
    chk("t4_rd_addr", 64'(bus.mem_rd_addr), 64'h048);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_err_set", 64'(bus.err_oob), 64'd1);
    repeat (6) step();
    @(negedge clk);
    chk("t4_err_sticky", 64'(bus.err_oob), 64'd1);
    step();

    // 5: reset with reads in flight
    drive(64'h9, 3'd0, 1'b0);
    step();
    drive(64'hA, 3'd1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_ready_rst", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("t5_req_count", 64'(bus.req_count), 64'd0);
    chk("t5_err_cleared", 64'(bus.err_oob), 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("t5_no_stale_out", 64'(seen), 64'd0);
    step();

    // 6: random traffic
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_acc = 0; n_cyc = 0; hold = 1'b0;
    while (n_acc < 10000 && n_cyc < 40000) begin
      if (!hold) begin
        if ($urandom_range(3) != 0)
          drive({($urandom_range(15) == 0) ? {21'd0, 32'($urandom)} : 53'd0, 11'($urandom)},
                3'($urandom), 1'($urandom));
        else
          bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        n_acc++;
        hold = 1'b0;
      end else begin
        hold = bus.in_valid;
      end
      step();
      n_cyc++;
    end
    chk("t6_accepts_done", 64'(n_acc), 64'd10000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    chk("t6_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("t6_req_count", 64'(bus.req_count), 64'd10000);
    chk("t6_out_idle", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
